aes_encrypt_core: RTL and testbench

//   Iterative AES block encryptor (FIPS-197), one round per clock, for 128- or 256-bit keys.

---
 rtl/aes_encrypt_core.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// -----------------------------------------------------------------------------
// aes_encrypt_core
//   Iterative AES (FIPS-197) block encryptor, one round per clock, for 128- or
//   256-bit keys. Round keys are expanded on the fly alongside the data rounds,
//   so no key storage beyond the current key window is needed. One block is in
//   flight at a time.
//
// Ports
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous, active-high reset
//   in_valid   in   1         in_data/in_key valid
//   in_ready   out  1         core can accept a block (IDLE)
//   in_data    in   128       plaintext, [127:120] = FIPS byte 0
//   in_key     in   KEY_BITS  cipher key, MSB byte = FIPS key byte 0
//   out_valid  out  1         out_data holds a finished ciphertext (DONE)
//   out_ready  in   1         consumer accepts out_data
//   out_data   out  128       ciphertext, same byte order as in_data
//   busy       out  1         round computation in progress (RUN)
// -----------------------------------------------------------------------------
module aes_encrypt_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // GF(2^8) / AES helper functions
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        gf_mul = p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, with 0 -> 0) followed
    // by the FIPS affine transform, instead of a stored table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, a;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        a    = gf_mul(x252, x2);
        sbox = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        sub_bytes = o;
    endfunction

    // Byte index k = row + 4*col lives at bits [127-8k -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        shift_rows = o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        mix_column = {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
                      s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
                      s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
                      xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        mix_columns = o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [127:0]          data_q, data_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [3:0]            round_q, round_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [127:0]          out_data_q, out_data_d;
    logic                  in_ready_q, out_valid_q, busy_q;

    logic [127:0]          rk_s;
    logic [KEY_BITS-1:0]   key_next_s;
    logic [7:0]            rcon_next_s;
    logic [127:0]          sr_s;
    logic [127:0]          round_out_s;

    // ------------------------------------------------------------------
    // On-the-fly key schedule
    // ------------------------------------------------------------------
    if (KEY_BITS == 128) begin : g_ks128
        logic [31:0] t_s, n0_s, n1_s, n2_s, n3_s;

        // Next AES-128 round key from the current one; rcon advances every round.
        always_comb begin
            t_s         = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h000000};
            n0_s        = key_q[127:96] ^ t_s;
            n1_s        = key_q[95:64]  ^ n0_s;
            n2_s        = key_q[63:32]  ^ n1_s;
            n3_s        = key_q[31:0]   ^ n2_s;
            rk_s        = {n0_s, n1_s, n2_s, n3_s};
            key_next_s  = {n0_s, n1_s, n2_s, n3_s};
            rcon_next_s = xtime(rcon_q);
        end
    end else if (KEY_BITS == 256) begin : g_ks256
        logic [31:0] t_s, n0_s, n1_s, n2_s, n3_s;

        // 8-word key window: round 1 uses the second key half as-is; from round 2
        // on, four new words are derived, with RotWord+rcon only on even rounds.
        always_comb begin
            t_s         = 32'h0000_0000;
            rcon_next_s = rcon_q;
            if (round_q[0]) begin
                t_s = sub_word(key_q[31:0]);
            end else begin
                t_s         = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h000000};
                rcon_next_s = xtime(rcon_q);
            end
            n0_s = key_q[255:224] ^ t_s;
            n1_s = key_q[223:192] ^ n0_s;
            n2_s = key_q[191:160] ^ n1_s;
            n3_s = key_q[159:128] ^ n2_s;
            if (round_q == 4'd1) begin
                rk_s        = key_q[127:0];
                key_next_s  = key_q;
                rcon_next_s = rcon_q;
            end else begin
                rk_s        = {n0_s, n1_s, n2_s, n3_s};
                key_next_s  = {key_q[127:0], n0_s, n1_s, n2_s, n3_s};
            end
        end
    end else begin : g_bad_key_bits
        $error("aes_encrypt_core: KEY_BITS must be 128 or 256");
    end

    // ------------------------------------------------------------------
    // Round datapath: the final round skips MixColumns
    // ------------------------------------------------------------------
    // One cipher round on the current state.
    always_comb begin
        sr_s = shift_rows(sub_bytes(data_q));
        if (round_q == NR) begin
            round_out_s = sr_s ^ rk_s;
        end else begin
            round_out_s = mix_columns(sr_s) ^ rk_s;
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        key_d      = key_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data ^ in_key[KEY_BITS-1 -: 128];
                    key_d   = in_key;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                data_d = round_out_s;
                key_d  = key_next_s;
                rcon_d = rcon_next_s;
                if (round_q == NR) begin
                    out_data_d = round_out_s;
                    state_d    = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= 128'h0;
            key_q       <= '0;
            round_q     <= 4'd0;
            rcon_q      <= 8'h01;
            out_data_q  <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            key_q       <= key_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// -----------------------------------------------------------------------------
// tb_aes_encrypt_core
//   Directed-vector bench for aes_encrypt_core using the FIPS-197 example
//   vectors. Instance "a" uses a 128-bit key, instance "b" a 256-bit key.
// -----------------------------------------------------------------------------
module tb_aes_encrypt_core;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] in_data_a, in_key_a, out_data_a;
    logic         rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] in_data_b, out_data_b;
    logic [255:0] in_key_b;

    int checks   = 0;
    int failures = 0;

    aes_encrypt_core #(.KEY_BITS(128)) u_dut_a (
        .clk(clk), .reset(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_key(in_key_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a)
    );

    aes_encrypt_core #(.KEY_BITS(256)) u_dut_b (
        .clk(clk), .reset(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_key(in_key_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one block to instance a for a single edge, then scramble inputs.
    task automatic send_a(input logic [127:0] pt, input logic [127:0] key);
        in_valid_a = 1'b1;
        in_data_a  = pt;
        in_key_a   = key;
        step();
        in_valid_a = 1'b0;
        in_data_a  = ~pt;
        in_key_a   = ~key;
    endtask

    // Edges after acceptance until out_valid; 0 if the bound expires.
    task automatic wait_done_a(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (out_valid_a) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake_a(input string tag);
        out_ready_a = 1'b1;
        step();
        check_eq({tag, "_ov_clr"}, 128'(out_valid_a), 128'd0);
        check_eq({tag, "_rdy_set"}, 128'(in_ready_a), 128'd1);
        out_ready_a = 1'b0;
    endtask

    initial begin
        int lat;
        int acc_q[$];
        logic [127:0] out_q[$];
        int nacc;
        logic acc, hs;
        logic [127:0] hs_data;

        rst_a = 1'b1; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0; in_key_a = '0;
        rst_b = 1'b1; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0; in_key_b = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Reset state
        check_eq("rst_in_ready", 128'(in_ready_a), 128'd1);
        check_eq("rst_out_valid", 128'(out_valid_a), 128'd0);
        check_eq("rst_out_data", out_data_a, 128'h0);
        check_eq("rst_busy", 128'(busy_a), 128'd0);

        // Test 1: FIPS C.1 AES-128, latency 10
        send_a(P1, K1);
        check_eq("t1_busy", 128'(busy_a), 128'd1);
        check_eq("t1_in_ready_run", 128'(in_ready_a), 128'd0);
        wait_done_a(lat);
        check_eq("t1_latency", 128'(lat), 128'd10);
        check_eq("t1_ct", out_data_a, C1);
        check_eq("t1_busy_done", 128'(busy_a), 128'd0);
        check_eq("t1_in_ready_done", 128'(in_ready_a), 128'd0);
        handshake_a("t1");

        // Test 2: FIPS appendix B vector
        send_a(P2, K2);
        wait_done_a(lat);
        check_eq("t2_latency", 128'(lat), 128'd10);
        check_eq("t2_ct", out_data_a, C2);
        handshake_a("t2");

        // Test 3: FIPS C.3 AES-256, latency 14
        in_valid_b = 1'b1;
        in_data_b  = P1;
        in_key_b   = K3;
        step();
        in_valid_b = 1'b0;
        in_data_b  = ~P1;
        in_key_b   = ~K3;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (out_valid_b) begin
                lat = i;
                break;
            end
        end
        check_eq("t3_latency", 128'(lat), 128'd14);
        check_eq("t3_ct", out_data_b, C3);
        out_ready_b = 1'b1;
        step();
        check_eq("t3_ov_clr", 128'(out_valid_b), 128'd0);
        out_ready_b = 1'b0;

        // Test 4: backpressure with a second block waiting
        send_a(P1, K1);
        wait_done_a(lat);
        in_valid_a = 1'b1;
        in_data_a  = P2;
        in_key_a   = K2;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("t4_ov_hold", 128'(out_valid_a), 128'd1);
            check_eq("t4_data_hold", out_data_a, C1);
            check_eq("t4_no_accept", 128'(in_ready_a), 128'd0);
        end
        out_ready_a = 1'b1;
        step();
        check_eq("t4_ov_clr", 128'(out_valid_a), 128'd0);
        check_eq("t4_rdy_set", 128'(in_ready_a), 128'd1);
        out_ready_a = 1'b0;
        step();
        in_valid_a = 1'b0;
        in_data_a  = '0;
        in_key_a   = '0;
        check_eq("t4_second_busy", 128'(busy_a), 128'd1);
        wait_done_a(lat);
        check_eq("t4_latency", 128'(lat), 128'd10);
        check_eq("t4_ct2", out_data_a, C2);
        handshake_a("t4");

        // Test 5: back-to-back streaming, vectors alternate 1,2,1,2,...
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        in_data_a   = P1;
        in_key_a    = K1;
        nacc        = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc     = in_valid_a & in_ready_a;
            hs      = out_valid_a & out_ready_a;
            hs_data = out_data_a;
            step();
            if (acc) begin
                acc_q.push_back(cyc);
                nacc++;
                in_data_a = (nacc % 2 == 1) ? P2 : P1;
                in_key_a  = (nacc % 2 == 1) ? K2 : K1;
            end
            if (hs) begin
                out_q.push_back(hs_data);
            end
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        check_eq("t5_nacc", 128'(acc_q.size()), 128'd5);
        check_eq("t5_nout", 128'(out_q.size()), 128'd5);
        check_eq("t5_first_acc", 128'(acc_q[0]), 128'd0);
        for (int k = 1; k < 5; k++) begin
            check_eq("t5_gap", 128'(acc_q[k] - acc_q[k-1]), 128'd12);
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("t5_ct_order", out_q[k], (k % 2 == 0) ? C1 : C2);
        end
        step();

        // Test 6: reset at round 5 aborts the block
        send_a(P2, K2);
        repeat (4) step();
        rst_a = 1'b1;
        #1;
        check_eq("t6_ov", 128'(out_valid_a), 128'd0);
        check_eq("t6_data", out_data_a, 128'h0);
        check_eq("t6_in_ready", 128'(in_ready_a), 128'd1);
        check_eq("t6_busy", 128'(busy_a), 128'd0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) step();
        check_eq("t6_idle_ov", 128'(out_valid_a), 128'd0);
        check_eq("t6_idle_data", out_data_a, 128'h0);
        send_a(P1, K1);
        wait_done_a(lat);
        check_eq("t6_latency", 128'(lat), 128'd10);
        check_eq("t6_ct", out_data_a, C1);
        handshake_a("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
